// File: rtl/w_stage_ctl_reg.sv
// w_stage_ctl_reg: memory-to-writeback pipeline register for the Y86-64 core.
// Adds stall/bubble control, destination register ids and a halt FSM that
// freezes the stage once a non-AOK, non-bubble status is latched.
// Optional performance counters are enabled by defining W_STAGE_PERF_CNT_EN.
module w_stage_ctl_reg #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned STAT_W    = 3,
  parameter int unsigned ICODE_W   = 4,
  parameter int unsigned REG_W     = 4,
  parameter int unsigned STAT_AOK  = 1,
  parameter int unsigned STAT_BUB  = 0,
  parameter int unsigned ICODE_NOP = 1,
  parameter int unsigned RNONE     = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_stall,
  input  logic               w_bubble,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [ICODE_W-1:0] m_icode,
  input  logic [DATA_W-1:0]  m_valE,
  input  logic [DATA_W-1:0]  m_valM,
  input  logic [REG_W-1:0]   m_dstE,
  input  logic [REG_W-1:0]   m_dstM,
  output logic [STAT_W-1:0]  w_stat,
  output logic [ICODE_W-1:0] w_icode,
  output logic [DATA_W-1:0]  w_valE,
  output logic [DATA_W-1:0]  w_valM,
  output logic [REG_W-1:0]   w_dstE,
  output logic [REG_W-1:0]   w_dstM,
`ifdef W_STAGE_PERF_CNT_EN
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_bubble,
`endif
  output logic               halted,
  output logic               ctrl_err
);

  localparam logic [STAT_W-1:0]  AOK_C   = STAT_W'(STAT_AOK);
  localparam logic [STAT_W-1:0]  BUB_C   = STAT_W'(STAT_BUB);
  localparam logic [ICODE_W-1:0] NOP_C   = ICODE_W'(ICODE_NOP);
  localparam logic [REG_W-1:0]   RNONE_C = REG_W'(RNONE);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   do_load;
  logic   do_bubble;
  logic   set_err;

  // Halt FSM register; halted is a direct decode of the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  // Next-state and datapath control; stall outranks bubble, HALTED ignores both.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_bubble = 1'b0;
    set_err   = 1'b0;
    if (state == S_RUN) begin
      set_err = w_stall & w_bubble;
      if (!w_stall) begin
        if (w_bubble) begin
          do_bubble = 1'b1;
        end else begin
          do_load = 1'b1;
          if (m_stat != AOK_C && m_stat != BUB_C) state_nxt = S_HALTED;
        end
      end
    end
  end

  assign halted = (state == S_HALTED);

  // Pipeline payload: load, inject bubble, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_stat  <= BUB_C;
      w_icode <= NOP_C;
      w_valE  <= '0;
      w_valM  <= '0;
      w_dstE  <= RNONE_C;
      w_dstM  <= RNONE_C;
    end else if (do_bubble) begin
      w_stat  <= BUB_C;
      w_icode <= NOP_C;
      w_valE  <= '0;
      w_valM  <= '0;
      w_dstE  <= RNONE_C;
      w_dstM  <= RNONE_C;
    end else if (do_load) begin
      w_stat  <= m_stat;
      w_icode <= m_icode;
      w_valE  <= m_valE;
      w_valM  <= m_valM;
      w_dstE  <= m_dstE;
      w_dstM  <= m_dstM;
    end
  end

  // Sticky flag for the illegal stall+bubble combination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctrl_err <= 1'b0;
    else if (set_err) ctrl_err <= 1'b1;
  end

`ifdef W_STAGE_PERF_CNT_EN
  // Event counters; only RUN-state edges count, so they freeze once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
      perf_bubble  <= '0;
    end else if (state == S_RUN) begin
      if (do_load && m_stat == AOK_C) perf_retired <= perf_retired + 32'd1;
      if (w_stall)                    perf_stall   <= perf_stall + 32'd1;
      if (do_bubble)                  perf_bubble  <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_w_stage_ctl_reg.sv
// Directed self-checking bench for w_stage_ctl_reg.
// Define W_STAGE_PERF_CNT_EN to also exercise the performance counters.
module tb_w_stage_ctl_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_stall, w_bubble;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  m_dstE, m_dstM;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode;
  logic [63:0] w_valE, w_valM;
  logic [3:0]  w_dstE, w_dstM;
  logic        halted, ctrl_err;
`ifdef W_STAGE_PERF_CNT_EN
  logic [31:0] perf_retired, perf_stall, perf_bubble;
`endif

  int checks   = 0;
  int failures = 0;

  // Packed view of every output: stat, icode, valE, valM, dstE, dstM, halted, ctrl_err
  logic [144:0] obs;
  logic [144:0] exp_v;
  assign obs = {w_stat, w_icode, w_valE, w_valM, w_dstE, w_dstM, halted, ctrl_err};

  localparam logic [144:0] RST_V = {3'd0, 4'd1, 64'd0, 64'd0, 4'd15, 4'd15, 1'b0, 1'b0};

  always #5 clk = ~clk;

  w_stage_ctl_reg #(
    .DATA_W(64), .STAT_W(3), .ICODE_W(4), .REG_W(4),
    .STAT_AOK(1), .STAT_BUB(0), .ICODE_NOP(1), .RNONE(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .w_stall(w_stall), .w_bubble(w_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .w_stat(w_stat), .w_icode(w_icode), .w_valE(w_valE), .w_valM(w_valM),
    .w_dstE(w_dstE), .w_dstM(w_dstM),
`ifdef W_STAGE_PERF_CNT_EN
    .perf_retired(perf_retired), .perf_stall(perf_stall), .perf_bubble(perf_bubble),
`endif
    .halted(halted), .ctrl_err(ctrl_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_stall = 1'b0; w_bubble = 1'b0;
    drive(3'd1, 4'd2, 64'hAAAA, 64'hBBBB, 4'd1, 4'd2);
    tick(); tick();
    checks++;
    if (obs !== RST_V) begin
      $display("FAIL reset_initial got=%h want=%h", obs, RST_V); failures++;
    end
    rst_n = 1'b1;
    tick();
    // asynchronous assertion between edges must clear the loaded contents at once
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_V) begin
      $display("FAIL reset_async got=%h want=%h", obs, RST_V); failures++;
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    drive(3'd1, 4'd6, 64'h1234, 64'hDEAD, 4'd3, 4'd15);
    tick();
    exp_v = {3'd1, 4'd6, 64'h1234, 64'hDEAD, 4'd3, 4'd15, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL pass_through got=%h want=%h", obs, exp_v); failures++;
    end
    drive(3'd1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 4'd0, 4'd14);
    tick();
    exp_v = {3'd1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 4'd0, 4'd14, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL pass_wide got=%h want=%h", obs, exp_v); failures++;
    end
  endtask

  task automatic test_stall_bubble();
    drive(3'd1, 4'd3, 64'h55, 64'h0, 4'd4, 4'd15);
    tick();
    exp_v = {3'd1, 4'd3, 64'h55, 64'h0, 4'd4, 4'd15, 1'b0, 1'b0};
    w_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // includes a stalled HLT status, which must neither load nor halt
      drive(3'(i + 1), 4'(i + 7), 64'(100 + i), 64'(200 + i), 4'(i), 4'(i + 1));
      tick();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL stall_hold_%0d got=%h want=%h", i, obs, exp_v); failures++;
      end
    end
    w_stall = 1'b0; w_bubble = 1'b1;
    drive(3'd3, 4'd5, 64'h77, 64'h88, 4'd1, 4'd2);
    tick();
    checks++;
    if (obs !== RST_V) begin
      $display("FAIL bubble_inject got=%h want=%h", obs, RST_V); failures++;
    end
    w_bubble = 1'b0;
  endtask

  task automatic test_halt();
    drive(3'd2, 4'd0, 64'h77, 64'h88, 4'd2, 4'd3);
    tick();
    exp_v = {3'd2, 4'd0, 64'h77, 64'h88, 4'd2, 4'd3, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL halt_entry got=%h want=%h", obs, exp_v); failures++;
    end
    drive(3'd1, 4'd6, 64'h99, 64'h11, 4'd5, 4'd6);
    for (int i = 0; i < 5; i++) begin
      // controls cycle through bubble, stall and the illegal pair; all ignored
      w_bubble = (i == 1 || i == 3);
      w_stall  = (i == 2 || i == 3);
      tick();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL halt_frozen_%0d got=%h want=%h", i, obs, exp_v); failures++;
      end
    end
    w_stall = 1'b0; w_bubble = 1'b0;
  endtask

  task automatic test_halt_recovery();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_V) begin
      $display("FAIL recovery_reset got=%h want=%h", obs, RST_V); failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd1, 4'd6, 64'hABCD, 64'h4321, 4'd7, 4'd8);
    tick();
    exp_v = {3'd1, 4'd6, 64'hABCD, 64'h4321, 4'd7, 4'd8, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL recovery_pass got=%h want=%h", obs, exp_v); failures++;
    end
`ifdef W_STAGE_PERF_CNT_EN
    checks++;
    if ({perf_retired, perf_stall, perf_bubble} !== {32'd1, 32'd0, 32'd0}) begin
      $display("FAIL perf_after_recovery got=%0d/%0d/%0d want=1/0/0",
               perf_retired, perf_stall, perf_bubble); failures++;
    end
`endif
  endtask

  task automatic test_ctrl_err();
    w_stall = 1'b1; w_bubble = 1'b1;
    drive(3'd4, 4'd9, 64'h1, 64'h2, 4'd0, 4'd0);
    tick();
    exp_v = {3'd1, 4'd6, 64'hABCD, 64'h4321, 4'd7, 4'd8, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL ctrl_err_set got=%h want=%h", obs, exp_v); failures++;
    end
`ifdef W_STAGE_PERF_CNT_EN
    checks++;
    if ({perf_stall, perf_bubble} !== {32'd1, 32'd0}) begin
      $display("FAIL perf_ctrl_err got=%0d/%0d want=1/0", perf_stall, perf_bubble); failures++;
    end
`endif
    w_stall = 1'b0; w_bubble = 1'b0;
    drive(3'd1, 4'd2, 64'h42, 64'h43, 4'd9, 4'd10);
    tick();
    exp_v = {3'd1, 4'd2, 64'h42, 64'h43, 4'd9, 4'd10, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL ctrl_err_sticky got=%h want=%h", obs, exp_v); failures++;
    end
  endtask

  task automatic test_bubble_no_halt();
    // bubble with an error status on the inputs must not halt
    w_bubble = 1'b1;
    drive(3'd2, 4'd0, 64'h5, 64'h6, 4'd1, 4'd1);
    tick();
    exp_v = {3'd0, 4'd1, 64'd0, 64'd0, 4'd15, 4'd15, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL bubble_no_halt got=%h want=%h", obs, exp_v); failures++;
    end
    w_bubble = 1'b0;
    // loading a raw bubble status (0) through the datapath must not halt either
    drive(3'd0, 4'd3, 64'h7, 64'h8, 4'd2, 4'd3);
    tick();
    exp_v = {3'd0, 4'd3, 64'h7, 64'h8, 4'd2, 4'd3, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL load_bub_stat got=%h want=%h", obs, exp_v); failures++;
    end
    // ADR status halts as well
    drive(3'd3, 4'd5, 64'h9, 64'hA, 4'd4, 4'd5);
    tick();
    exp_v = {3'd3, 4'd5, 64'h9, 64'hA, 4'd4, 4'd5, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL adr_halt got=%h want=%h", obs, exp_v); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall_bubble();
    test_halt();
    test_halt_recovery();
    test_ctrl_err();
    test_bubble_no_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

endmodule
